// File: rtl/axi_pkg.sv
// Shared AXI definitions for the write-path splitter and its ingress-side merger.
// Contents:
//   - burst-type and response-code constants
//   - aw_hdr_t: AW header (addr, id, burst, size, len) at the default bus widths
//   - split_state_e: splitter FSM states
//   - slot_free(): one-entry register may accept a new load this cycle
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_ID_W   = 4;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_ID_W-1:0]   id;
    logic [1:0]            burst;
    logic [2:0]            size;
    logic [7:0]            len;
  } aw_hdr_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } split_state_e;

  // A one-entry slot can be reloaded when empty or when it drains this cycle.
  function automatic logic slot_free(input logic valid, input logic ready);
    return !valid || ready;
  endfunction

endpackage

// File: rtl/axi_reg_slice.sv
// One-entry valid/ready register stage.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   load                write data into the slot (caller guarantees free=1)
//   data [WIDTH]        payload to load
//   free                slot may be loaded this cycle
//   out_data [WIDTH]    registered payload, held while out_valid && !out_ready
//   out_valid           slot holds a payload
//   out_ready           downstream accepts the payload
module axi_reg_slice
  import axi_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic             free,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  assign free = slot_free(out_valid, out_ready);

  // Payload only changes on a load, and loads only happen when the slot is
  // free, so the payload is stable while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_splitter.sv
// Splits a merged write-request stream (header + data on every beat) into
// registered AXI AW and W channels, tracks bursts issued on AW that still
// await a B response, and passes B responses upstream.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   in_addr/id/burst/size/len          burst header, sampled on the first beat
//   in_wdata/in_wstrb/in_last          beat payload and upstream last marker
//   in_valid/in_ready                  merged-stream handshake
//   out_aw*                            registered AW channel
//   out_w*                             registered W channel (wlast from len count)
//   in_bid/in_bresp/in_bvalid/in_bready   B from the AXI slave
//   out_bid/out_bresp/out_bvalid/out_bready   B towards upstream
//   err_len                            sticky: in_last disagreed with len count
//   err_unexp_b                        sticky: B arrived with nothing outstanding
module axi_splitter
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 64,
  parameter int ID_WIDTH        = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   in_addr,
  input  logic [ID_WIDTH-1:0]     in_id,
  input  logic [1:0]              in_burst,
  input  logic [2:0]              in_size,
  input  logic [7:0]              in_len,
  input  logic [DATA_WIDTH-1:0]   in_wdata,
  input  logic [DATA_WIDTH/8-1:0] in_wstrb,
  input  logic                    in_last,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [ADDR_WIDTH-1:0]   out_awaddr,
  output logic [ID_WIDTH-1:0]     out_awid,
  output logic [1:0]              out_awburst,
  output logic [2:0]              out_awsize,
  output logic [7:0]              out_awlen,
  output logic                    out_awvalid,
  input  logic                    out_awready,
  output logic [DATA_WIDTH-1:0]   out_wdata,
  output logic [DATA_WIDTH/8-1:0] out_wstrb,
  output logic                    out_wlast,
  output logic                    out_wvalid,
  input  logic                    out_wready,
  input  logic [ID_WIDTH-1:0]     in_bid,
  input  logic [1:0]              in_bresp,
  input  logic                    in_bvalid,
  output logic                    in_bready,
  output logic [ID_WIDTH-1:0]     out_bid,
  output logic [1:0]              out_bresp,
  output logic                    out_bvalid,
  input  logic                    out_bready,
  output logic                    err_len,
  output logic                    err_unexp_b
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int AW_WIDTH   = ADDR_WIDTH + ID_WIDTH + 2 + 3 + 8;
  localparam int W_WIDTH    = DATA_WIDTH + STRB_WIDTH + 1;
  localparam int OCNT_W     = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [OCNT_W:0] MAX_CNT = (OCNT_W + 1)'(MAX_OUTSTANDING);

  split_state_e        state_reg, state_next;
  logic [7:0]          beat_cnt_reg;
  logic [7:0]          len_reg;
  logic [OCNT_W-1:0]   outstanding_reg;
  logic                err_len_reg;
  logic                err_unexp_b_reg;

  logic                aw_free, w_free;
  logic                accept, final_beat;
  logic                room;
  logic [OCNT_W:0]     in_flight;
  logic                aw_hs, b_hs, no_outstanding;
  logic [AW_WIDTH-1:0] aw_q;
  logic [W_WIDTH-1:0]  w_q;

  // A header still sitting in the AW register will become outstanding, so it
  // counts against the limit before it handshakes.
  assign in_flight = {1'b0, outstanding_reg} + (OCNT_W + 1)'(out_awvalid);
  assign room      = in_flight < MAX_CNT;

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    accept     = 1'b0;
    final_beat = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        in_ready   = w_free && aw_free && room;
        final_beat = (in_len == 8'd0);
        accept     = in_valid && in_ready;
        if (accept && !final_beat) state_next = ST_BURST;
      end
      ST_BURST: begin
        in_ready   = w_free;
        // beat_cnt_reg beats already taken; this one is beat beat_cnt_reg+1
        final_beat = (beat_cnt_reg == len_reg);
        accept     = in_valid && in_ready;
        if (accept && final_beat) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_reg <= 8'd0;
      len_reg      <= 8'd0;
      err_len_reg  <= 1'b0;
    end else if (accept) begin
      if (state_reg == ST_IDLE) begin
        beat_cnt_reg <= 8'd1;
        len_reg      <= in_len;
      end else begin
        beat_cnt_reg <= beat_cnt_reg + 8'd1;
      end
      // The burst always ends on the len count; a disagreeing in_last is
      // only reported.
      if (in_last != final_beat) err_len_reg <= 1'b1;
    end
  end

  axi_reg_slice #(.WIDTH(AW_WIDTH)) u_aw_slice (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept && (state_reg == ST_IDLE)),
    .data      ({in_addr, in_id, in_burst, in_size, in_len}),
    .free      (aw_free),
    .out_data  (aw_q),
    .out_valid (out_awvalid),
    .out_ready (out_awready)
  );

  axi_reg_slice #(.WIDTH(W_WIDTH)) u_w_slice (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .data      ({in_wdata, in_wstrb, final_beat}),
    .free      (w_free),
    .out_data  (w_q),
    .out_valid (out_wvalid),
    .out_ready (out_wready)
  );

  assign {out_awaddr, out_awid, out_awburst, out_awsize, out_awlen} = aw_q;
  assign {out_wdata, out_wstrb, out_wlast} = w_q;

  // B path: combinational pass-through. With nothing outstanding the
  // response is swallowed so a stray B can never block the slave.
  assign no_outstanding = (outstanding_reg == '0);
  assign out_bid        = in_bid;
  assign out_bresp      = in_bresp;
  assign out_bvalid     = in_bvalid && !no_outstanding;
  assign in_bready      = no_outstanding ? 1'b1 : out_bready;

  assign aw_hs = out_awvalid && out_awready;
  assign b_hs  = out_bvalid && out_bready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_reg <= '0;
      err_unexp_b_reg <= 1'b0;
    end else begin
      if (aw_hs && !b_hs) begin
        outstanding_reg <= outstanding_reg + 1'b1;
      end else if (b_hs && !aw_hs) begin
        outstanding_reg <= outstanding_reg - 1'b1;
      end
      if (in_bvalid && no_outstanding) err_unexp_b_reg <= 1'b1;
    end
  end

  assign err_len     = err_len_reg;
  assign err_unexp_b = err_unexp_b_reg;

endmodule

// File: doc/axi_splitter.md
Name: axi_splitter

Overview:
- Converts one merged write-request stream into independent AXI AW and W channels, and returns B responses upstream. Each beat of the merged stream carries data and the burst header.
- Sits between the cache write-back path and the AXI master port; it is the counterpart of the AW/W merger on the ingress side.
- Registered outputs on AW and W; outstanding-burst tracking gates new bursts; B responses are passed through with accounting.

Parameters:
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 64, AXI data width; strobe width is DATA_WIDTH/8
- ID_WIDTH, 4, AXI ID width
- MAX_OUTSTANDING, 4, bursts issued on AW with no B yet received; power of 2, ≥1

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_addr  in  ADDR_WIDTH  burst address, sampled on first beat
- in_id  in  ID_WIDTH  burst ID, sampled on first beat
- in_burst  in  2  burst type, sampled on first beat
- in_size  in  3  beat size, sampled on first beat
- in_len  in  8  beats−1, sampled on first beat
- in_wdata  in  DATA_WIDTH  beat data
- in_wstrb  in  DATA_WIDTH/8  beat strobes
- in_last  in  1  upstream last-beat marker
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid&&in_ready
- out_awaddr/out_awid/out_awburst/out_awsize/out_awlen  out  ADDR_WIDTH/ID_WIDTH/2/3/8  registered AW payload
- out_awvalid  out  1  AW valid
- out_awready  in  1  AW ready
- out_wdata/out_wstrb  out  DATA_WIDTH/DATA_WIDTH/8  registered W payload
- out_wlast  out  1  generated last
- out_wvalid  out  1  W valid
- out_wready  in  1  W ready
- in_bid  in  ID_WIDTH  AXI B ID
- in_bresp  in  2  AXI B response
- in_bvalid  in  1  B valid
- in_bready  out  1  B ready
- out_bid/out_bresp  out  ID_WIDTH/2  upstream response
- out_bvalid  out  1  upstream response valid
- out_bready  in  1  upstream response ready
- err_len  out  1  sticky: in_last disagreed with in_len count
- err_unexp_b  out  1  sticky: B received with zero outstanding

Behaviour:
- Reset (async, rst_n low): all valid outputs 0; payload registers 0; state IDLE; beat counter 0; outstanding count 0; err flags 0. Reset mid-burst abandons the burst with no flush.
- FSM IDLE (next beat is first of a burst):
  - in_ready = W slot free && AW slot free && outstanding+pending_aw < MAX_OUTSTANDING.
  - On accept: load AW register (out_awvalid=1) and W register. Beat counter = 1. Go BURST if in_len!=0, else stay IDLE.
- FSM BURST: in_ready = W slot free. On accept: load W register, increment counter. Return to IDLE when counter == latched len.
- "Slot free" = slot valid is 0, or slot handshake occurs this cycle. Loading a slot is allowed in the same cycle as its handshake.
- Latency: input beat to out_wvalid/out_awvalid is 1 cycle. AW and W complete independently; AW may lag or lead W by any number of cycles.
- out_wlast = 1 on the beat where counter reaches latched len. It is not derived from in_last.
- err_len is set on any accepted beat where in_last != (that beat is the final beat). The burst still ends by the len count.
- Outstanding counter:
  - +1 on AW handshake; −1 on B pass-through handshake.
  - Simultaneous +1 and −1: unchanged.
  - Never exceeds MAX_OUTSTANDING.
  - pending_aw counts the AW register while it is valid.
- B path: combinational pass-through. out_bvalid = in_bvalid && outstanding!=0; in_bready = out_bready.
- B with outstanding==0: in_bready=1, response dropped, err_unexp_b set.
- Stable-payload rule: every out_* payload is held constant while its valid is high and ready is low.

Decomposition:
- Shared package axi_pkg:
  - burst-type constants FIXED/INCR/WRAP.
  - resp constants OKAY/EXOKAY/SLVERR/DECERR.
  - typedef aw_hdr_t (addr, id, burst, size, len), reused by the merger.
- One natural sub-module, axi_reg_slice: a one-entry valid/ready register, instantiated for AW (payload aw_hdr_t) and for W (data, strb, last).

Test Plan:
- Single-beat burst, addr 0x1000, id 3, len 0, all readies high → AW and W with wlast=1 both appear the next cycle; one B id 3 is forwarded; outstanding returns to 0.
- 4-beat INCR (len 3), out_awready held low for 6 cycles, out_wready high → all 4 W beats complete with wlast on beat 4. AW is held stable and then handshakes. The next burst is stalled until AW completes.
- MAX_OUTSTANDING=4, five 1-beat bursts, no B responses → in_ready=0 on the 5th first-beat. After one B handshake, the 5th burst is accepted the following cycle.
- len 2 with in_last asserted on beat 2 → err_len=1; out_wlast still on beat 3; the next beat is treated as a new header.
- in_bvalid with zero outstanding → in_bready=1, out_bvalid=0, err_unexp_b=1 and it stays set.
- rst_n low during beat 2 of a len-7 burst → all valids 0 asynchronously. After release, a new 1-beat burst is accepted in IDLE with a correct header.
